// File: rtl/rr_trace_packer_if.sv
// rr_trace_packer_if: record-in / beat-out handshake bundle for rr_trace_packer.
//   in_data/in_width/in_valid -> record offered by the staging FIFO
//   in_ready                  <- record accepted when in_valid & in_ready
//   out_data/out_size/out_last/out_valid -> packed beat toward the AXI write FIFO
//   out_ready                 <- beat consumed when out_valid & out_ready
// slave: the packer side; master: the side that feeds records and drains beats.
interface rr_trace_packer_if #(
  parameter int IN_WIDTH   = 2560,
  parameter int OUT_WIDTH  = 512,
  parameter int SIZE_WIDTH = 32
);
  logic [IN_WIDTH-1:0]   in_data;
  logic [SIZE_WIDTH-1:0] in_width;
  logic                  in_valid;
  logic                  in_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic [SIZE_WIDTH-1:0] out_size;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_width, in_valid, out_ready,
    input  in_ready, out_data, out_size, out_last, out_valid
  );

  modport slave (
    input  in_data, in_width, in_valid, out_ready,
    output in_ready, out_data, out_size, out_last, out_valid
  );
endinterface

// File: rtl/rr_trace_packer.sv
// rr_trace_packer: packs variable-width, ALIGN-granular trace records into dense
// OUT_WIDTH beats for the record-logging DRAM writeback path.
// Ports:
//   clk        clock
//   sync_rst_n asynchronous active-low reset
//   bus        record input / beat output handshakes (rr_trace_packer_if.slave)
//   flush_req  one-cycle pulse: drain the accumulator once the held record is sliced
//   flush_done one-cycle pulse when the flush has completed
//   err_width  sticky: a record with an illegal width was dropped
//   beat_cnt   output beats handed off (wraps)
//   bit_cnt    record bits accepted (wraps)
module rr_trace_packer #(
  parameter int IN_WIDTH   = 2560,
  parameter int OUT_WIDTH  = 512,
  parameter int ALIGN      = 32,
  parameter int SIZE_WIDTH = 32,
  parameter int CNT_WIDTH  = 48,
  parameter int FLUSH_PAD  = 0
) (
  input  logic                 clk,
  input  logic                 sync_rst_n,
  rr_trace_packer_if.slave     bus,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 err_width,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic [CNT_WIDTH-1:0] bit_cnt
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SLICE = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [SIZE_WIDTH-1:0] OW = SIZE_WIDTH'(OUT_WIDTH);
  localparam logic [SIZE_WIDTH-1:0] IW = SIZE_WIDTH'(IN_WIDTH);
  localparam logic [SIZE_WIDTH-1:0] AL = SIZE_WIDTH'(ALIGN);

  logic [1:0]             state;
  logic                   rst_done;
  logic                   flush_pend;
  logic [IN_WIDTH-1:0]    rec;
  logic [SIZE_WIDTH-1:0]  rem;
  logic [SIZE_WIDTH-1:0]  acc;
  logic [2*OUT_WIDTH-1:0] acc_data;

  logic                   out_free;
  logic                   accept;
  logic                   width_bad;
  logic [SIZE_WIDTH-1:0]  chunk;
  logic [SIZE_WIDTH-1:0]  sum;
  logic [2*OUT_WIDTH-1:0] merged;
  logic [IN_WIDTH-1:0]    in_mask;

  assign bus.in_ready = rst_done && (state == S_IDLE) && !flush_pend;
  assign flush_done   = (state == S_DONE);

  always_comb begin
    out_free  = !bus.out_valid || bus.out_ready;
    accept    = bus.in_valid && bus.in_ready;
    width_bad = ((bus.in_width % AL) != '0) || (bus.in_width > IW);
    chunk     = (rem > OW) ? OW : rem;
    sum       = acc + chunk;
    // Accumulator bits at and above acc are always zero, so OR-merging is safe.
    merged    = acc_data | ({{OUT_WIDTH{1'b0}}, rec[OUT_WIDTH-1:0]} << acc);
    // Record bits beyond in_width are cleared at latch time so slices need no masking.
    in_mask   = ~({IN_WIDTH{1'b1}} << bus.in_width);
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state         <= S_IDLE;
      rst_done      <= 1'b0;
      flush_pend    <= 1'b0;
      rec           <= '0;
      rem           <= '0;
      acc           <= '0;
      acc_data      <= '0;
      bus.out_data  <= '0;
      bus.out_size  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_valid <= 1'b0;
      err_width     <= 1'b0;
      beat_cnt      <= '0;
      bit_cnt       <= '0;
    end else begin
      rst_done <= 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        beat_cnt      <= beat_cnt + 1'b1;
        bus.out_valid <= 1'b0;
      end
      if (flush_req) flush_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (accept) begin
            if (bus.in_width != '0) begin
              if (width_bad) begin
                err_width <= 1'b1;
              end else begin
                rec     <= bus.in_data & in_mask;
                rem     <= bus.in_width;
                bit_cnt <= bit_cnt + CNT_WIDTH'(bus.in_width);
                state   <= S_SLICE;
              end
            end
          end else if (flush_pend) begin
            state <= S_FLUSH;
          end
        end
        S_SLICE: begin
          if (out_free) begin
            if (sum >= OW) begin
              bus.out_data  <= merged[OUT_WIDTH-1:0];
              bus.out_size  <= OW;
              bus.out_last  <= 1'b0;
              bus.out_valid <= 1'b1;
              acc_data      <= merged >> OUT_WIDTH;
              acc           <= sum - OW;
            end else begin
              acc_data <= merged;
              acc      <= sum;
            end
            rec <= rec >> OUT_WIDTH;
            rem <= rem - chunk;
            if (rem == chunk) state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          // With acc already zero, a free output register means any final beat
          // has been (or is now being) handed off, so the flush is complete.
          if (out_free) begin
            if (acc != '0) begin
              bus.out_data  <= acc_data[OUT_WIDTH-1:0];
              bus.out_size  <= (FLUSH_PAD != 0) ? OW : acc;
              bus.out_last  <= 1'b1;
              bus.out_valid <= 1'b1;
              acc           <= '0;
              acc_data      <= '0;
            end else begin
              state <= S_DONE;
            end
          end
        end
        default: begin
          // Clearing here also discards any request that arrived while pending.
          state      <= S_IDLE;
          flush_pend <= 1'b0;
        end
      endcase
    end
  end

  a_acc_bound: assert property (@(posedge clk) disable iff (!sync_rst_n) acc < OW);
endmodule
